// File: rtl/conv_mxfp6tobf16.sv
// -----------------------------------------------------------------------------
// conv_mxfp6tobf16
//
// Streaming MX-to-BF16 decoder. Accepts one MX block (k FP6 elements plus one
// shared 8-bit exponent) over a valid/ready handshake and returns it as BF16
// values, `lanes` per beat, over k/lanes output beats.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_mx_valid / o_mx_ready input block handshake
//   i_mx_vec[k]             elements, each {sign, exp, man}
//   i_mx_exp                shared exponent X, biased 127
//   o_bf16_valid / i_bf16_ready  output beat handshake
//   o_bf16_vec[lanes]       decoded BF16 values of the current beat
//   o_bf16_last             high on the final beat of a block
//
// Build option: define MX_CONV_BF16_SUBNORM_EN to produce BF16 subnormals for
// results with E <= 0 (round to nearest even); otherwise they flush to +-0.
// -----------------------------------------------------------------------------
module conv_mxfp6tobf16 #(
  parameter int exp_width = 3,
  parameter int man_width = 2,
  parameter int bit_width = 1 + exp_width + man_width,
  parameter int k         = 32,
  parameter int lanes     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_mx_valid,
  output logic                 o_mx_ready,
  input  logic [bit_width-1:0] i_mx_vec [k],
  input  logic [7:0]           i_mx_exp,
  output logic                 o_bf16_valid,
  input  logic                 i_bf16_ready,
  output logic [15:0]          o_bf16_vec [lanes],
  output logic                 o_bf16_last
);

  localparam int BEATS  = k / lanes;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = (k > 1) ? $clog2(k) : 1;
  localparam int BIAS_E = (1 << (exp_width - 1)) - 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  generate
    if ((k % lanes) != 0) begin : g_lanes_chk
      $error("conv_mxfp6tobf16: k must be a multiple of lanes");
    end
  endgenerate

`ifdef MX_CONV_BF16_SUBNORM_EN
  // Denormalise {1,frac} by (1-E) with round-to-nearest-even. The 8-bit result
  // is placed directly above the sign-less exponent LSB, so a rounding carry
  // into bit 7 naturally yields the minimum normal (exponent field 1).
  function automatic logic [7:0] f_subnorm(input logic [6:0] frac, input int ev);
    logic [23:0] w_sh;
    logic [7:0]  w_ip;
    logic        w_rup;
    int          sh;
    sh = 1 - ev;
    if (sh > 8) return 8'h00;  // value below half an ulp: rounds to zero
    w_sh  = {1'b1, frac, 16'h0000} >> sh;
    w_ip  = w_sh[23:16];
    w_rup = w_sh[15] & ((|w_sh[14:0]) | w_ip[0]);
    return w_ip + 8'(w_rup);
  endfunction
`endif

  // Decode one element against shared exponent x.
  function automatic logic [15:0] f_decode(input logic [7:0] x,
                                           input logic [bit_width-1:0] el);
    logic                 s;
    logic [exp_width-1:0] e;
    logic [man_width-1:0] m;
    logic [6:0]           frac;
    logic [15:0]          res;
    int                   ev;
    int                   p;
    s    = el[bit_width-1];
    e    = el[man_width +: exp_width];
    m    = el[man_width-1:0];
    frac = '0;
    ev   = 0;
    p    = 0;
    if (e != '0) begin
      ev   = int'(x) + int'(e) - BIAS_E;
      frac = 7'(m) << (7 - man_width);
    end else begin
      // Element subnormal: find the leading one, drop it, left-align the rest.
      for (int i = 0; i < man_width; i++) begin
        if (m[i]) p = i;
      end
      ev   = int'(x) + 1 - BIAS_E - (man_width - p);
      frac = 7'(16'(m) << (7 - p));
    end

    if (x == 8'hFF) begin
      res = 16'h7FC0;
    end else if ((e == '0) && (m == '0)) begin
      res = {s, 15'h0000};
    end else if (ev >= 255) begin
      res = {s, 8'hFF, 7'h00};
    end else if (ev <= 0) begin
`ifdef MX_CONV_BF16_SUBNORM_EN
      res = {s, 7'h00, f_subnorm(frac, ev)};
`else
      res = {s, 15'h0000};
`endif
    end else begin
      res = {s, ev[7:0], frac};
    end
    return res;
  endfunction

  typedef enum logic {IDLE, SEND} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [BEAT_W-1:0]    r_beat;
  logic [BEAT_W-1:0]    w_beat_next;
  logic [bit_width-1:0] r_vec [k];
  logic [7:0]           r_exp;
  logic                 w_mx_accept;
  logic                 w_beat_take;
  logic                 w_last_beat;

  assign w_last_beat  = (r_beat == LAST_BEAT);
  assign o_bf16_valid = (r_state == SEND);
  assign o_bf16_last  = o_bf16_valid && w_last_beat;
  // Ready during the last beat lets a new block land on the same edge the
  // final beat leaves, so blocks stream without a bubble.
  assign o_mx_ready   = i_rst_n && ((r_state == IDLE) ||
                        ((r_state == SEND) && w_last_beat && i_bf16_ready));
  assign w_mx_accept  = i_mx_valid && o_mx_ready;
  assign w_beat_take  = o_bf16_valid && i_bf16_ready;

  always_comb begin
    w_state_next = r_state;
    w_beat_next  = r_beat;
    if (w_mx_accept) begin
      w_state_next = SEND;
      w_beat_next  = '0;
    end else if (w_beat_take) begin
      if (w_last_beat) begin
        w_state_next = IDLE;
        w_beat_next  = '0;
      end else begin
        w_beat_next = r_beat + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_next;
      r_beat  <= w_beat_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_exp <= '0;
      for (int i = 0; i < k; i++) r_vec[i] <= '0;
    end else if (w_mx_accept) begin
      r_exp <= i_mx_exp;
      for (int i = 0; i < k; i++) r_vec[i] <= i_mx_vec[i];
    end
  end

  // Decode is combinational from the block register; outputs are zero when
  // no beat is presented.
  generate
    for (genvar gi = 0; gi < lanes; gi++) begin : g_lane
      logic [IDX_W-1:0] w_idx;
      assign w_idx          = IDX_W'(int'(r_beat) * lanes + gi);
      assign o_bf16_vec[gi] = o_bf16_valid ? f_decode(r_exp, r_vec[w_idx]) : 16'h0000;
    end
  endgenerate

endmodule

// File: tb/tb_conv_mxfp6tobf16.sv
`timescale 1ns/1ps
module tb_conv_mxfp6tobf16;
  localparam int K     = 32;
  localparam int LANES = 8;
  localparam int BW    = 6;
  localparam int BEATS = K / LANES;

  typedef struct packed {
    logic                  last;
    logic [LANES*16-1:0]   data;
  } beat_t;

  typedef struct packed {
    logic [7:0]      x;
    logic [K*BW-1:0] el;
    logic            directed;
    logic [15:0]     dexp;
  } blk_t;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_mx_valid;
  logic          o_mx_ready;
  logic [BW-1:0] i_mx_vec [K];
  logic [7:0]    i_mx_exp;
  logic          o_bf16_valid;
  logic          i_bf16_ready;
  logic [15:0]   o_bf16_vec [LANES];
  logic          o_bf16_last;

  beat_t sb_q[$];
  blk_t  blk_q[$];
  blk_t  cur_blk;
  int    n_vec    = 0;
  int    n_err    = 0;
  bit    acc_flag = 0;
  bit    gap_en   = 0;
  bit    rdy_rand = 0;
  bit    p1_mode  = 0;
  int    p1_c     = 0;
  int    pops     = 0;

  conv_mxfp6tobf16 #(
    .exp_width(3),
    .man_width(2),
    .k(K),
    .lanes(LANES)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_mx_valid   (i_mx_valid),
    .o_mx_ready   (o_mx_ready),
    .i_mx_vec     (i_mx_vec),
    .i_mx_exp     (i_mx_exp),
    .o_bf16_valid (o_bf16_valid),
    .i_bf16_ready (i_bf16_ready),
    .o_bf16_vec   (o_bf16_vec),
    .o_bf16_last  (o_bf16_last)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode through real arithmetic: value = a * 2^(ex-127).
  function automatic logic [15:0] ref_bf16(input logic [7:0] x, input logic [BW-1:0] el);
    real  a;
    int   ex;
    int   r;
    int   e;
    int   m;
    logic s;
    s = el[5];
    e = int'(el[4:2]);
    m = int'(el[1:0]);
    if (x == 8'hFF) return 16'h7FC0;
    if (e == 0 && m == 0) return {s, 15'h0000};
    a  = (e > 0) ? (1.0 + m / 4.0) : (m / 4.0);
    ex = int'(x) + ((e > 0) ? e : 1) - 3;
    while (a >= 2.0) begin a = a / 2.0; ex++; end
    while (a < 1.0) begin a = a * 2.0; ex--; end
    if (ex >= 255) return {s, 8'hFF, 7'h00};
    if (ex <= 0) begin
`ifdef MX_CONV_BF16_SUBNORM_EN
      begin
        real q;
        real fr;
        q = a * 128.0;
        for (int i = ex; i < 1; i++) q = q / 2.0;
        r  = $rtoi(q);
        fr = q - r;
        if (fr > 0.5 || (fr == 0.5 && (r % 2) == 1)) r++;
        return {s, 15'(r)};
      end
`else
      return {s, 15'h0000};
`endif
    end
    r = $rtoi((a - 1.0) * 128.0);
    return {s, 8'(ex), 7'(r)};
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    case ($urandom_range(0, 3))
      0:       b.x = 8'($urandom_range(0, 6));
      1:       b.x = 8'($urandom_range(248, 255));
      default: b.x = 8'($urandom_range(100, 150));
    endcase
    for (int i = 0; i < K; i++) b.el[i*BW +: BW] = 6'($urandom_range(0, 63));
    b.directed = 1'b0;
    b.dexp     = 16'h0000;
    return b;
  endfunction

  function automatic blk_t dir_blk(input logic [7:0] x, input logic [5:0] el, input logic [15:0] ex);
    blk_t b;
    b.x = x;
    for (int i = 0; i < K; i++) b.el[i*BW +: BW] = el;
    b.directed = 1'b1;
    b.dexp     = ex;
    return b;
  endfunction

  task automatic push_block(input blk_t b);
    beat_t bt;
    for (int bi = 0; bi < BEATS; bi++) begin
      bt.last = (bi == BEATS - 1);
      for (int j = 0; j < LANES; j++)
        bt.data[j*16 +: 16] = b.directed ? b.dexp : ref_bf16(b.x, b.el[(bi*LANES+j)*BW +: BW]);
      sb_q.push_back(bt);
    end
  endtask

  // One clock cycle: check outputs, drive inputs, then book the transfers that
  // will happen on the coming rising edge.
  task automatic tick();
    beat_t exp_b;
    blk_t  b;
    @(negedge i_clk);
    if (o_bf16_valid) begin
      if (sb_q.size() == 0) begin
        chk_eq("spurious_beat", 32'(o_bf16_valid), 32'd0);
      end else begin
        exp_b = sb_q[0];
        for (int j = 0; j < LANES; j++)
          chk_eq($sformatf("lane%0d", j), 32'(o_bf16_vec[j]), 32'(exp_b.data[j*16 +: 16]));
        chk_eq("last", 32'(o_bf16_last), 32'(exp_b.last));
      end
    end else begin
      chk_eq("last_idle", 32'(o_bf16_last), 32'd0);
      if (p1_mode && sb_q.size() > 0) chk_eq("p1_valid", 32'(o_bf16_valid), 32'd1);
    end

    if (acc_flag) begin
      i_mx_valid = 1'b0;
      acc_flag   = 1'b0;
    end
    if (!i_mx_valid && blk_q.size() > 0 && !(gap_en && $urandom_range(0, 2) == 0)) begin
      b       = blk_q.pop_front();
      cur_blk = b;
      i_mx_exp = b.x;
      for (int i = 0; i < K; i++) i_mx_vec[i] = b.el[i*BW +: BW];
      i_mx_valid = 1'b1;
    end
    i_bf16_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    if (o_bf16_valid && i_bf16_ready && sb_q.size() > 0) begin
      void'(sb_q.pop_front());
      pops++;
    end
    if (p1_mode && o_bf16_valid && i_mx_valid)
      chk_eq("p1_mx_ready", 32'(o_mx_ready), 32'(p1_c % BEATS == BEATS - 1));
    if (p1_mode && o_bf16_valid) p1_c++;
    if (i_mx_valid && o_mx_ready) begin
      push_block(cur_blk);
      acc_flag = 1'b1;
    end
  endtask

  task automatic drain(input int limit);
    int c;
    c = 0;
    while ((blk_q.size() > 0 || i_mx_valid || sb_q.size() > 0) && c < limit) begin
      tick();
      c++;
    end
    chk_eq("drain_pending", 32'(sb_q.size() + blk_q.size() + int'(i_mx_valid && !acc_flag)), 32'd0);
  endtask

  initial begin
    blk_t b;
    int   c;
    i_rst_n      = 1'b0;
    i_mx_valid   = 1'b0;
    i_bf16_ready = 1'b0;
    i_mx_exp     = 8'h00;
    for (int i = 0; i < K; i++) i_mx_vec[i] = '0;

    // Reset state
    repeat (2) @(negedge i_clk);
    chk_eq("rst_valid", 32'(o_bf16_valid), 32'd0);
    chk_eq("rst_last", 32'(o_bf16_last), 32'd0);
    chk_eq("rst_mx_ready", 32'(o_mx_ready), 32'd0);
    for (int j = 0; j < LANES; j++) chk_eq($sformatf("rst_vec%0d", j), 32'(o_bf16_vec[j]), 32'd0);
    i_rst_n = 1'b1;
    #1;
    chk_eq("rel_mx_ready", 32'(o_mx_ready), 32'd1);

    // Phase 1: directed values, back-to-back blocks, sink always ready
    blk_q.push_back(dir_blk(8'h7F, 6'b011111, 16'h41E0));
    blk_q.push_back(dir_blk(8'h7F, 6'b100100, 16'hBE80));
    blk_q.push_back(dir_blk(8'h7F, 6'b000010, 16'h3E00));
    blk_q.push_back(dir_blk(8'h7F, 6'b100000, 16'h8000));
    blk_q.push_back(dir_blk(8'hFE, 6'b011100, 16'h7F80));
`ifdef MX_CONV_BF16_SUBNORM_EN
    blk_q.push_back(dir_blk(8'h00, 6'b000100, 16'h0010));
`else
    blk_q.push_back(dir_blk(8'h00, 6'b000100, 16'h0000));
`endif
    b          = rand_blk();
    b.x        = 8'hFF;
    b.directed = 1'b1;
    b.dexp     = 16'h7FC0;
    blk_q.push_back(b);
    blk_q.push_back(rand_blk());
    p1_mode = 1'b1;
    drain(200);
    p1_mode = 1'b0;

    // Phase 2: random blocks, random input gaps and sink stalls
    rdy_rand = 1'b1;
    gap_en   = 1'b1;
    for (int n = 0; n < 20; n++) blk_q.push_back(rand_blk());
    drain(3000);

    // Phase 3: reset in the middle of a block
    rdy_rand = 1'b0;
    gap_en   = 1'b0;
    blk_q.push_back(rand_blk());
    pops = 0;
    c    = 0;
    while (pops < 2 && c < 50) begin
      tick();
      c++;
    end
    chk_eq("rst_setup_beats", 32'(pops), 32'd2);
    @(negedge i_clk);
    i_rst_n    = 1'b0;
    i_mx_valid = 1'b0;
    acc_flag   = 1'b0;
    @(negedge i_clk);
    chk_eq("midrst_valid", 32'(o_bf16_valid), 32'd0);
    chk_eq("midrst_last", 32'(o_bf16_last), 32'd0);
    chk_eq("midrst_mx_ready", 32'(o_mx_ready), 32'd0);
    chk_eq("midrst_vec0", 32'(o_bf16_vec[0]), 32'd0);
    sb_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk_eq("postrst_mx_ready", 32'(o_mx_ready), 32'd1);
    chk_eq("postrst_valid", 32'(o_bf16_valid), 32'd0);
    blk_q.push_back(rand_blk());
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
